// File: rtl/mul_shiftadd_pkg.sv
// Shared step-counter constants for the sequential arithmetic units
// (shift-and-add multiplier and subtract-and-shift divider).
package mul_shiftadd_pkg;

  // Counter value at which operands are captured.
  localparam int PC_LOAD = 0;

  // Width of the step counter for a given operand width. It has one spare bit
  // of headroom above the HOLD value.
  function automatic int pc_width(input int data_w);
    return $clog2(data_w + 2) + 1;
  endfunction

  // Counter value of the final step, in which the result is completed.
  function automatic int pc_last(input int data_w);
    return data_w;
  endfunction

  // Counter value while the finished result is held.
  function automatic int pc_hold(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/mul_shiftadd_absval.sv
// Combinational magnitude of an operand. When sign is set the value is read as
// two's complement. The most negative value maps to 2^(DATA_W-1), which is
// read as unsigned.
module mul_absval #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] value,
  input  logic              sign,
  output logic [DATA_W-1:0] magnitude
);

  // Negate only if the operand is signed and negative.
  assign magnitude = (sign && value[DATA_W-1]) ? (~value + DATA_W'(1)) : value;

endmodule

// File: rtl/mul_shiftadd.sv
// Sequential shift-and-add multiplier. It adds one partial-product bit per
// clock and uses the same en/done protocol as the divider.
// Optional build macro: MUL_SHIFTADD_SIGN_EN enables signed operands. When the
// macro is not defined, every operation is unsigned and the sign input is
// ignored.
//
// pc value       | meaning
// 0              | LOAD: capture operands (as magnitudes when signed)
// 1..DATA_W-1    | STEP: conditional add, then shift right
// DATA_W         | LAST: final step, negate if needed, raise done
// DATA_W+1       | HOLD: keep product and done while en stays high
module mul_shiftadd
  import mul_shiftadd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sign,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int PCW = pc_width(DATA_W);
  localparam logic [PCW-1:0] PC_LOAD_V = PCW'(PC_LOAD);
  localparam logic [PCW-1:0] PC_LAST_V = PCW'(pc_last(DATA_W));
  localparam logic [PCW-1:0] PC_HOLD_V = PCW'(pc_hold(DATA_W));

  logic [PCW-1:0]      pc;
  logic [2*DATA_W-1:0] p;
  logic [DATA_W-1:0]   mc;
  logic                sign_reg;

  logic [DATA_W-1:0]   mc_load;
  logic [DATA_W-1:0]   mp_load;
  logic                sign_load;
  logic [DATA_W:0]     s;
  logic [2*DATA_W-1:0] stepped;
  logic [2*DATA_W-1:0] last_val;

`ifdef MUL_SHIFTADD_SIGN_EN
  mul_absval #(.DATA_W(DATA_W)) u_abs_mc (
    .value     (multiplicand),
    .sign      (sign),
    .magnitude (mc_load)
  );

  mul_absval #(.DATA_W(DATA_W)) u_abs_mp (
    .value     (multiplier),
    .sign      (sign),
    .magnitude (mp_load)
  );

  assign sign_load = sign & (multiplicand[DATA_W-1] ^ multiplier[DATA_W-1]);
  // Negating a zero product gives zero, so the result can never turn nonzero here.
  assign last_val  = sign_reg ? (~stepped + (2*DATA_W)'(1)) : stepped;

  // The result sign is captured at LOAD, so later changes on the inputs have no effect.
  always_ff @(posedge clk) begin
    if (pc == PC_LOAD_V) sign_reg <= sign_load;
  end
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign mc_load     = multiplicand;
  assign mp_load     = multiplier;
  assign sign_load   = 1'b0;
  assign sign_reg    = sign_load;
  assign last_val    = stepped;
`endif

  // Shift-and-add step: add the multiplicand if the current multiplier bit is set, then shift right.
  always_comb begin
    s       = {1'b0, p[2*DATA_W-1:DATA_W]} + {1'b0, (p[0] ? mc : {DATA_W{1'b0}})};
    stepped = {s, p[DATA_W-1:1]};
  end

  // Sequencer. rst or a low en clears the unit; otherwise pc moves through LOAD, STEP, LAST, HOLD.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pc   <= '0;
      p    <= '0;
      done <= 1'b0;
    end else if (pc == PC_LOAD_V) begin
      mc <= mc_load;
      p  <= {{DATA_W{1'b0}}, mp_load};
      pc <= PCW'(1);
    end else if (pc < PC_LAST_V) begin
      p  <= stepped;
      pc <= pc + PCW'(1);
    end else if (pc == PC_LAST_V) begin
      p    <= last_val;
      done <= 1'b1;
      pc   <= PC_HOLD_V;
    end
  end

  assign product = p;

endmodule

// File: tb/tb_mul_shiftadd.sv
// Directed testbench for mul_shiftadd at DATA_W=32. Signed expectations
// follow MUL_SHIFTADD_SIGN_EN.
module tb_mul_shiftadd;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sign;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        done;
  logic [63:0] product;

  int vectors   = 0;
  int miscompar = 0;

  mul_shiftadd #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold en low for one edge, then run an operation. The number of edges up to done is returned.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int edges);
    en = 1'b0;
    tick();
    multiplicand = a;
    multiplier   = b;
    sign         = s;
    en           = 1'b1;
    edges        = 0;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sign = 1'b0; multiplicand = 32'd5; multiplier = 32'd5;
    tick(); tick();
    vectors++;
    if (product !== 64'd0 || done !== 1'b0) begin
      miscompar++;
      $display("FAIL reset: product=%h done=%b, required product=0 done=0", product, done);
    end
    rst = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int edges;
    run_op(32'd7, 32'd6, 1'b0, edges);
    vectors++;
    if (edges !== 33) begin
      miscompar++;
      $display("FAIL basic_latency: edges=%0d, required 33", edges);
    end
    vectors++;
    if (product !== 64'h000000000000002A) begin
      miscompar++;
      $display("FAIL basic_product: got %h, required 000000000000002a", product);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (done !== 1'b1 || product !== 64'h2A) begin
        miscompar++;
        $display("FAIL basic_hold[%0d]: done=%b product=%h, required done=1 product=2a", i, done, product);
      end
    end
  endtask

  task automatic test_vectors();
    logic [31:0] a_v [6];
    logic [31:0] b_v [6];
    logic        s_v [6];
    logic [63:0] e_v [6];
    int edges;
    a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'hFFFFFFFF; s_v[0] = 1'b0; e_v[0] = 64'hFFFFFFFE00000001;
    a_v[1] = 32'hFFFFFFFF; b_v[1] = 32'hFFFFFFFF; s_v[1] = 1'b1;
    a_v[2] = 32'hFFFFFFFD; b_v[2] = 32'd5;        s_v[2] = 1'b1;
    a_v[3] = 32'h80000000; b_v[3] = 32'h80000000; s_v[3] = 1'b1; e_v[3] = 64'h4000000000000000;
    a_v[4] = 32'd0;        b_v[4] = 32'hFFFFFFF7; s_v[4] = 1'b1; e_v[4] = 64'd0;
    a_v[5] = 32'hFFFFFFFF; b_v[5] = 32'd2;        s_v[5] = 1'b1;
`ifdef MUL_SHIFTADD_SIGN_EN
    e_v[1] = 64'h0000000000000001;
    e_v[2] = 64'hFFFFFFFFFFFFFFF1;
    e_v[5] = 64'hFFFFFFFFFFFFFFFE;
`else
    e_v[1] = 64'hFFFFFFFE00000001;
    e_v[2] = 64'h00000004FFFFFFF1;
    e_v[5] = 64'h00000001FFFFFFFE;
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(a_v[i], b_v[i], s_v[i], edges);
      vectors++;
      if (edges !== 33 || product !== e_v[i]) begin
        miscompar++;
        $display("FAIL vector[%0d]: edges=%0d product=%h, required edges=33 product=%h", i, edges, product, e_v[i]);
      end
    end
  endtask

  task automatic test_abort();
    int edges;
    en = 1'b0;
    tick();
    multiplicand = 32'd1000; multiplier = 32'd1000; sign = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    en = 1'b0;
    tick();
    vectors++;
    if (product !== 64'd0 || done !== 1'b0) begin
      miscompar++;
      $display("FAIL abort_clear: product=%h done=%b, required product=0 done=0", product, done);
    end
    // Restart with 12 x 12 and change the operands right after the LOAD edge.
    multiplicand = 32'd12; multiplier = 32'd12; en = 1'b1;
    tick();
    multiplicand = 32'hDEADBEEF; multiplier = 32'h12345678; sign = 1'b1;
    edges = 1;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    vectors++;
    if (edges !== 33 || product !== 64'h90) begin
      miscompar++;
      $display("FAIL abort_restart: edges=%0d product=%h, required edges=33 product=90", edges, product);
    end
  endtask

  task automatic test_rst_mid();
    int edges;
    en = 1'b0;
    tick();
    multiplicand = 32'd123; multiplier = 32'd456; sign = 1'b0; en = 1'b1;
    for (int i = 0; i < 19; i++) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (product !== 64'd0 || done !== 1'b0) begin
      miscompar++;
      $display("FAIL rst_mid_clear: product=%h done=%b, required product=0 done=0", product, done);
    end
    rst = 1'b0;
    edges = 0;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    vectors++;
    if (edges !== 33 || product !== 64'd56088) begin
      miscompar++;
      $display("FAIL rst_mid_result: edges=%0d product=%h, required edges=33 product=%h", edges, product, 64'd56088);
    end
    // A reset during HOLD also clears the unit, even with en still high.
    rst = 1'b1;
    tick();
    vectors++;
    if (product !== 64'd0 || done !== 1'b0) begin
      miscompar++;
      $display("FAIL rst_hold_clear: product=%h done=%b, required product=0 done=0", product, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int edges;
    run_op(32'h00010000, 32'h00010000, 1'b0, edges);
    vectors++;
    if (edges !== 33 || product !== 64'h0000000100000000) begin
      miscompar++;
      $display("FAIL b2b_first: edges=%0d product=%h, required edges=33 product=0000000100000000", edges, product);
    end
    run_op(32'hAAAAAAAA, 32'd3, 1'b0, edges);
    vectors++;
    if (edges !== 33 || product !== 64'h00000001FFFFFFFE) begin
      miscompar++;
      $display("FAIL b2b_second: edges=%0d product=%h, required edges=33 product=00000001fffffffe", edges, product);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sign = 1'b0; multiplicand = '0; multiplier = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompar);
    $finish;
  end

endmodule
